// File: rtl/sb_packer.sv
// Synapse-buffer write packer: packs variable-precision weights LSB-first into
// dense BIT_WIDTH-bit words, with a one-word output slot and a flush for the tail.
module sb_packer #(
  parameter int BIT_WIDTH  = 16,
  parameter int SHIFT_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIT_WIDTH-1:0]  i_in,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [SHIFT_BITS-1:0] i_s,
  input  logic                  i_flush,
  output logic [BIT_WIDTH-1:0]  o_out,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [SHIFT_BITS-1:0] o_fill
);

  localparam int                ACC_W     = 2 * BIT_WIDTH;
  localparam logic [SHIFT_BITS:0] WORD_BITS = (SHIFT_BITS + 1)'(BIT_WIDTH);

  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      acc_next;
  logic [SHIFT_BITS-1:0] fill;
  logic [SHIFT_BITS:0]   s_eff;
  logic [SHIFT_BITS:0]   nfill;
  logic [BIT_WIDTH-1:0]  mask;
  logic [BIT_WIDTH-1:0]  v;
  logic                  xfer;
  logic                  take_in;
  logic                  take_flush;

  // NOTE: every variable gets a value before any conditional override, so no latch is inferred.
  always_comb begin
    s_eff = {1'b0, i_s};
    if (s_eff > WORD_BITS) s_eff = WORD_BITS;
    // A shift by the full width yields zero, so s == BIT_WIDTH gives an all-ones mask.
    mask     = ~({BIT_WIDTH{1'b1}} << s_eff);
    v        = i_in & mask;
    acc_next = acc | (ACC_W'(v) << fill);
    nfill    = {1'b0, fill} + s_eff;
  end

  assign o_ready    = !o_valid || i_ready;
  assign xfer       = o_valid && i_ready;
  assign take_in    = i_valid && o_ready && (s_eff != '0);
  // An input always wins over a flush; the flush waits for a cycle with i_valid low.
  assign take_flush = i_flush && !i_valid && o_ready && (fill != '0);
  assign o_fill     = fill;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      fill    <= '0;
      o_out   <= '0;
      o_valid <= 1'b0;
    end else begin
      if (xfer) o_valid <= 1'b0;
      if (take_in) begin
        if (nfill >= WORD_BITS) begin
          o_out   <= acc_next[BIT_WIDTH-1:0];
          o_valid <= 1'b1;
          acc     <= acc_next >> BIT_WIDTH;
          fill    <= SHIFT_BITS'(nfill - WORD_BITS);
        end else begin
          acc  <= acc_next;
          fill <= nfill[SHIFT_BITS-1:0];
        end
      end else if (take_flush) begin
        // Bits at and above fill are already zero, so the low word is the padded tail.
        o_out   <= acc[BIT_WIDTH-1:0];
        o_valid <= 1'b1;
        acc     <= '0;
        fill    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sb_packer.sv
// Self-checking bench for sb_packer: expected words are queued as stimulus is
// driven and popped when the DUT transfers a word downstream.
module tb_sb_packer;

  localparam int BW = 16;
  localparam int SB = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] i_in;
  logic          i_valid;
  logic          o_ready;
  logic [SB-1:0] i_s;
  logic          i_flush;
  logic [BW-1:0] o_out;
  logic          o_valid;
  logic          i_ready;
  logic [SB-1:0] o_fill;

  int n_checks = 0;
  int n_fail   = 0;
  logic [BW-1:0] exp_q[$];

  sb_packer #(.BIT_WIDTH(BW), .SHIFT_BITS(SB)) dut (
    .clk(clk), .rst(rst), .i_in(i_in), .i_valid(i_valid), .o_ready(o_ready),
    .i_s(i_s), .i_flush(i_flush), .o_out(o_out), .o_valid(o_valid),
    .i_ready(i_ready), .o_fill(o_fill)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: a word is compared on the negedge before the edge that transfers it.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) check("unexpected_word", 32'(exp_q.size()), 32'd1);
      else check("word", 32'(o_out), 32'(exp_q.pop_front()));
    end
  end

  task automatic send(input int s, input logic [BW-1:0] val);
    bit done = 0;
    i_s     = SB'(s);
    i_in    = val;
    i_valid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (o_ready) done = 1;
    end
    if (!done) check("send_timeout", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic flush();
    bit done = 0;
    i_flush = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (o_fill == '0 && o_ready) done = 1;
    end
    if (!done) check("flush_timeout", 32'(o_fill), 32'd0);
    i_flush = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; i_in = '0; i_valid = 1'b0; i_s = '0; i_flush = 1'b0; i_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_fill",  32'(o_fill),  32'd0);
    check("rst_out",   32'(o_out),   32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);

    // Four nibbles make one word, valid for exactly one cycle.
    exp_q.push_back(16'h4321);
    send(4, 16'h1); send(4, 16'h2); send(4, 16'h3);
    check("t1_no_early_word", 32'(o_valid), 32'd0);
    send(4, 16'h4);
    check("t1_valid", 32'(o_valid), 32'd1);
    check("t1_fill",  32'(o_fill),  32'd0);
    idle(1);
    check("t1_valid_drop", 32'(o_valid), 32'd0);

    // Upper bits beyond the precision are masked.
    exp_q.push_back(16'hFFFD);
    send(4, 16'hABCD); send(4, 16'hF); send(4, 16'hF); send(4, 16'hF);
    idle(2);

    // Straddling word, then flush of the tail, then an empty flush.
    exp_q.push_back(16'hFFFF);
    repeat (4) send(5, 16'h1F);
    check("t3_fill4", 32'(o_fill), 32'd4);
    idle(1);
    exp_q.push_back(16'h000F);
    flush();
    check("t3_fill0", 32'(o_fill), 32'd0);
    flush();
    idle(2);
    check("t3_empty_flush", 32'(o_valid), 32'd0);

    // Mixed precisions, then full width.
    exp_q.push_back(16'hD5E5);
    send(3, 16'h5); send(13, 16'h1ABC);
    check("t4_fill", 32'(o_fill), 32'd0);
    exp_q.push_back(16'h1234);
    send(16, 16'h1234);
    check("t4_next_cycle", 32'(o_valid), 32'd1);
    idle(2);

    // Zero precision drops the input; oversize precision clamps to the word width.
    send(0, 16'hFFFF);
    check("s0_fill",  32'(o_fill),  32'd0);
    check("s0_valid", 32'(o_valid), 32'd0);
    exp_q.push_back(16'hA5A5);
    send(20, 16'hA5A5);
    check("clamp_fill", 32'(o_fill), 32'd0);
    idle(2);

    // Backpressure: slot full, input held off, then transfer and accept together.
    i_ready = 1'b0;
    exp_q.push_back(16'h5678);
    send(4, 16'h8); send(4, 16'h7); send(4, 16'h6); send(4, 16'h5);
    exp_q.push_back(16'h9999);
    i_s = SB'(16); i_in = 16'h9999; i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ready", 32'(o_ready), 32'd0);
      check("bp_out",   32'(o_out),   32'h5678);
      check("bp_valid", 32'(o_valid), 32'd1);
      check("bp_fill",  32'(o_fill),  32'd0);
    end
    @(posedge clk);
    #1 i_ready = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    check("bp_new_valid", 32'(o_valid), 32'd1);
    check("bp_new_out",   32'(o_out),   32'h9999);
    idle(2);

    // Reset mid-word discards pending bits.
    send(4, 16'h1); send(4, 16'h2); send(4, 16'h3);
    check("pre_rst_fill", 32'(o_fill), 32'd12);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_fill",  32'(o_fill),  32'd0);
    check("mid_rst_out",   32'(o_out),   32'd0);
    exp_q.push_back(16'hBEEF);
    send(16, 16'hBEEF);
    idle(3);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
